// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, arbiter state type and clog2 helper
package regfile_pkg;

  localparam int REG_BITS  = 3;
  localparam int WORD_SIZE = 8;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  // Smallest width able to index n items; callers clamp to at least 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rtl/regfile_write_arbiter_rr_pick.sv - combinational round-robin picker (one-hot grant plus winner index)
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);

  int idx;

  // Scan from the farthest position back toward ptr so the requester closest to ptr
  // (wrapping modulo NREQ, not modulo 2^PW) is the last one written and therefore wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        winner = PW'(idx);
        any    = 1'b1;
      end
    end
    gnt[winner] = any;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register file write port; REGARB_INIT_CLEAR_EN adds a post-reset zero sweep
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int RegBits  = REG_BITS,
  parameter int WordSize = WORD_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*RegBits-1:0]    req_reg,
  input  logic [NREQ*WordSize-1:0]   req_data,
  output logic [NREQ-1:0]            gnt,
  output logic                       rf_we,
  output logic [RegBits-1:0]         rf_inreg,
  output logic [WordSize-1:0]        rf_indata,
  output logic                       busy
);

  localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic            xfer;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt    (pick_gnt),
    .winner (winner),
    .any    (pick_any)
  );

  // Grants are suppressed in reset and during the sweep so requesters simply wait.
  assign gnt      = (rst_n && !busy) ? pick_gnt : '0;
  assign xfer     = rst_n & ~busy & pick_any;
  assign ptr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;

`ifdef REGARB_INIT_CLEAR_EN
  arb_state_t         state;
  logic [RegBits-1:0] cnt;
`else
  assign busy = 1'b0;
`endif

  // Write-port register stage: sweep entries in INIT, otherwise latch the granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b1;
      rf_inreg  <= '0;
      rf_indata <= '0;
      ptr       <= '0;
`ifdef REGARB_INIT_CLEAR_EN
      state     <= ARB_INIT;
      cnt       <= '0;
      busy      <= 1'b1;
`endif
    end else begin
`ifdef REGARB_INIT_CLEAR_EN
      if (state == ARB_INIT) begin
        rf_we     <= 1'b0;
        rf_inreg  <= cnt;
        rf_indata <= '0;
        cnt       <= cnt + 1'b1;
        if (&cnt) begin
          state <= ARB_RUN;
          busy  <= 1'b0;
        end
      end else
`endif
      if (xfer) begin
        rf_we     <= 1'b0;
        rf_inreg  <= req_reg[winner*RegBits +: RegBits];
        rf_indata <= req_data[winner*WordSize +: WordSize];
        ptr       <= ptr_next;
      end else begin
        rf_we <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench with a round-robin reference model for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int RB   = 3;
  localparam int WS   = 8;
`ifdef REGARB_INIT_CLEAR_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*RB-1:0] req_reg;
  logic [NREQ*WS-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              rf_we;
  logic [RB-1:0]     rf_inreg;
  logic [WS-1:0]     rf_indata;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  regfile_write_arbiter #(
    .NREQ     (NREQ),
    .RegBits  (RB),
    .WordSize (WS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .gnt       (gnt),
    .rf_we     (rf_we),
    .rf_inreg  (rf_inreg),
    .rf_indata (rf_indata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: winner is the requester at the smallest forward distance from ptr.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int best, bd, d;
    best = -1;
    bd   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        d = (i - p + NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  int m_ptr, m_inreg, m_indata, m_cnt, mw;
  bit m_we, m_busy;

  // Model of the write port, advanced on each edge from the inputs the DUT also sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_we = 1'b1; m_inreg = 0; m_indata = 0; m_busy = INIT_EN; m_cnt = 0;
    end else if (m_busy) begin
      m_we = 1'b0; m_inreg = m_cnt; m_indata = 0; m_cnt++;
      if (m_cnt == (1 << RB)) m_busy = 1'b0;
    end else begin
      mw = pick(req, m_ptr);
      if (mw >= 0) begin
        m_we     = 1'b0;
        m_inreg  = req_reg[mw*RB +: RB];
        m_indata = req_data[mw*WS +: WS];
        m_ptr    = (mw + 1) % NREQ;
      end else begin
        m_we = 1'b1;
      end
    end
  end

  // Requester rule: a pending request keeps its register and data unchanged.
  logic [NREQ-1:0]    pend = '0;
  logic [NREQ*RB-1:0] p_reg;
  logic [NREQ*WS-1:0] p_data;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && req[i] &&
            (req_reg[i*RB +: RB] !== p_reg[i*RB +: RB] || req_data[i*WS +: WS] !== p_data[i*WS +: WS])) begin
          miscompares++;
          $display("FAIL req_stable[%0d] changed while pending at %0t", i, $time);
        end
      end
      pend = req & ~gnt;
    end else begin
      pend = '0;
    end
    p_reg  = req_reg;
    p_data = req_data;
  end

  // Per-cycle comparison against the model, away from the active edge.
  int cw;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cw = m_busy ? -1 : pick(req, m_ptr);
      chk("gnt", gnt, (cw < 0) ? 0 : (1 << cw));
      chk("rf_we", rf_we, m_we);
      chk("rf_inreg", rf_inreg, m_inreg);
      chk("rf_indata", rf_indata, m_indata);
      chk("busy", busy, m_busy);
    end
  end

  logic [7:0] all_data [6];

  initial begin
    all_data = '{8'h11, 8'hA7, 8'h3C, 8'h11, 8'hA7, 8'h3C};
    rst_n    = 1'b0;
    req      = '0;
    req_reg  = {3'd6, 3'd5, 3'd2};
    req_data = {8'h3C, 8'hA7, 8'h11};

    #8;
    chk("reset_rf_we", rf_we, 1);
    chk("reset_rf_inreg", rf_inreg, 0);
    chk("reset_rf_indata", rf_indata, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, INIT_EN);
    #14 rst_n = 1'b1;

`ifdef REGARB_INIT_CLEAR_EN
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("init_we", rf_we, 0);
      chk("init_inreg", rf_inreg, k);
      chk("init_indata", rf_indata, 0);
      chk("init_gnt", gnt, 0);
      chk("init_busy", busy, (k < 7) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("init_done_we", rf_we, 1);
`endif

    // Single requester held three cycles.
    @(posedge clk); #2 req = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("solo_gnt", gnt, 3'b010);
      @(posedge clk); #1;
      chk("solo_we", rf_we, 0);
      chk("solo_inreg", rf_inreg, 5);
      chk("solo_indata", rf_indata, 8'hA7);
    end
    // ptr now 2: requester 0 alone moves it to 1.
    #1 req = 3'b001;
    @(negedge clk); chk("r0_gnt", gnt, 3'b001);
    @(posedge clk); #1 chk("r0_indata", rf_indata, 8'h11);
    // ptr=1 with req 0 and 2: 2 first, then 0.
    #1 req = 3'b101;
    @(negedge clk); chk("pair_gnt_a", gnt, 3'b100);
    @(posedge clk); #1 chk("pair_indata_a", rf_indata, 8'h3C);
    @(negedge clk); chk("pair_gnt_b", gnt, 3'b001);
    @(posedge clk); #1 chk("pair_indata_b", rf_indata, 8'h11);
    // ptr=1: a grant to 2 brings it back to 0.
    #1 req = 3'b100;
    @(posedge clk); #1 chk("r2_inreg", rf_inreg, 6);
    // All three requesting continuously from ptr=0.
    #1 req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("rr_gnt", gnt, 1 << (k % 3));
      @(posedge clk); #1 chk("rr_indata", rf_indata, all_data[k]);
    end
    #1 req = 3'b000;
    @(posedge clk); #1;
    chk("idle_we", rf_we, 1);
    chk("idle_hold", rf_indata, 8'h3C);

    // Reset during an in-flight write.
    #1 req = 3'b010;
    @(posedge clk); #1 chk("pre_rst_we", rf_we, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_we", rf_we, 1);
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_inreg", rf_inreg, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
`ifdef REGARB_INIT_CLEAR_EN
    chk("rel_gnt", gnt, 3'b000);
    @(posedge clk); #1;
    chk("rel_we", rf_we, 0);
    chk("rel_inreg", rf_inreg, 0);
    chk("rel_busy", busy, 1);
    for (int i = 0; i < 20 && busy === 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("rel_busy_done", busy, 0);
    chk("rel_first_gnt", gnt, 3'b010);
`else
    chk("rel_gnt", gnt, 3'b010);
    @(posedge clk); #1;
    chk("rel_we", rf_we, 0);
    chk("rel_inreg", rf_inreg, 5);
    chk("rel_indata", rf_indata, 8'hA7);
`endif
    #1 req = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
